// File: rtl/dbus_if_pkg.sv
// Shared constants and encodings for the data-bus interface that sits
// downstream of the MEM stage.
package dbus_if_pkg;

  localparam int          RegBusW   = 32;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  typedef enum logic [1:0] {
    DBUS_IDLE = 2'd0,
    DBUS_BUSY = 2'd1,
    DBUS_WAIT = 2'd2
  } dbus_state_e;

  // Stall vector layout: one bit per pipeline stage, PC first.
  localparam int STALL_PC_BIT  = 0;
  localparam int STALL_IF_BIT  = 1;
  localparam int STALL_ID_BIT  = 2;
  localparam int STALL_EX_BIT  = 3;
  localparam int STALL_MEM_BIT = 4;
  localparam int STALL_WB_BIT  = 5;
  localparam int STALL_W       = 6;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;

endpackage

// File: rtl/dbus_if.sv
// Runs MEM-stage load/store requests as single Wishbone-classic transfers,
// stalling the pipeline until ack and holding load data while MEM is frozen.
module dbus_if
  import dbus_if_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int HOLD_BIT = STALL_MEM_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_ce_i,
  input  logic                 cpu_we_i,
  input  logic [RegBusW-1:0]   cpu_addr_i,
  input  logic [3:0]           cpu_sel_i,
  input  logic [RegBusW-1:0]   cpu_data_i,
  output logic [RegBusW-1:0]   cpu_data_o,
  input  logic [STALL_W-1:0]   stall_i,
  input  logic                 flush_i,
  output logic                 stallreq_o,
  output logic                 bus_err_o,
  output logic [RegBusW-1:0]   wb_adr_o,
  output logic [RegBusW-1:0]   wb_dat_o,
  output logic                 wb_we_o,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_stb_o,
  output logic                 wb_cyc_o,
  input  logic [RegBusW-1:0]   wb_dat_i,
  input  logic                 wb_ack_i
);

  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam int          CNT_W  = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  dbus_state_e        state_q, state_d;
  logic [RegBusW-1:0] adr_q, adr_d;
  logic [RegBusW-1:0] dat_q, dat_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic               stb_q, stb_d;
  logic               cyc_q, cyc_d;
  logic [RegBusW-1:0] rd_buf_q, rd_buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bus_err_q, bus_err_d;
  logic               timeout_hit;
  logic [RegBusW-1:0] ack_data;

  assign timeout_hit = TO_EN && (cnt_q == CNT_MAX);
  // Stores return nothing to the MEM stage.
  assign ack_data    = we_q ? ZeroWord : wb_dat_i;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    sel_d      = sel_q;
    stb_d      = stb_q;
    cyc_d      = cyc_q;
    rd_buf_d   = rd_buf_q;
    cnt_d      = cnt_q;
    bus_err_d  = 1'b0;
    cpu_data_o = ZeroWord;
    stallreq_o = 1'b0;
    case (state_q)
      DBUS_IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i == ChipEnable && !flush_i) begin
          adr_d   = cpu_addr_i;
          dat_d   = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = DBUS_BUSY;
        end
      end
      DBUS_BUSY: begin
        if (flush_i) begin
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          state_d = DBUS_IDLE;
        end else if (wb_ack_i) begin
          cpu_data_o = ack_data;
          rd_buf_d   = ack_data;
          stb_d      = 1'b0;
          cyc_d      = 1'b0;
          state_d    = stall_i[HOLD_BIT] ? DBUS_WAIT : DBUS_IDLE;
        end else if (timeout_hit) begin
          stb_d     = 1'b0;
          cyc_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = DBUS_IDLE;
        end else begin
          stallreq_o = 1'b1;
          if (TO_EN && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DBUS_WAIT: begin
        cpu_data_o = rd_buf_q;
        if (flush_i || !stall_i[HOLD_BIT]) state_d = DBUS_IDLE;
      end
      default: state_d = DBUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DBUS_IDLE;
      adr_q     <= ZeroWord;
      dat_q     <= ZeroWord;
      we_q      <= WriteDisable;
      sel_q     <= 4'b0000;
      stb_q     <= 1'b0;
      cyc_q     <= 1'b0;
      rd_buf_q  <= ZeroWord;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      stb_q     <= stb_d;
      cyc_q     <= cyc_d;
      rd_buf_q  <= rd_buf_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = cyc_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_dbus_if.sv
// Directed bench for dbus_if: load, store, MEM hold, flush, timeout, async reset.
module tb_dbus_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i;
  logic [5:0]  stall_i;
  logic        flush_i, stallreq_o, bus_err_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
  logic [3:0]  wb_sel_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dbus_if #(.TIMEOUT(4), .HOLD_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stall_i(stall_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
    .bus_err_o(bus_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen at the falling edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_sel_i = s; cpu_data_i = d;
  endtask

  initial begin
    rst_n = 1'b0; cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_sel_i = 0;
    cpu_data_i = 0; stall_i = 0; flush_i = 0; wb_dat_i = 0; wb_ack_i = 0;

    // Reset state
    mid();
    chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(wb_stb_o), 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_stallreq", 32'(stallreq_o), 32'h0);
    chk("rst_data", cpu_data_o, 32'h0);
    chk("rst_err", 32'(bus_err_o), 32'h0);
    next_cycle(); rst_n = 1'b1;
    next_cycle();

    // Load, ack on 3rd BUSY cycle
    req(1'b0, 32'h0000_0040, 4'hF, 32'h0);
    mid(); chk("ld_idle_stallreq", 32'(stallreq_o), 32'h1);
    next_cycle(); cpu_ce_i = 0;
    mid(); chk("ld_b1_stallreq", 32'(stallreq_o), 32'h1);
    chk("ld_b1_cyc", 32'(wb_cyc_o), 32'h1);
    chk("ld_b1_stb", 32'(wb_stb_o), 32'h1);
    chk("ld_b1_adr", wb_adr_o, 32'h0000_0040);
    chk("ld_b1_we", 32'(wb_we_o), 32'h0);
    next_cycle();
    mid(); chk("ld_b2_stallreq", 32'(stallreq_o), 32'h1);
    next_cycle(); wb_ack_i = 1; wb_dat_i = 32'hDEAD_BEEF;
    mid(); chk("ld_ack_stallreq", 32'(stallreq_o), 32'h0);
    chk("ld_ack_data", cpu_data_o, 32'hDEAD_BEEF);
    next_cycle(); wb_ack_i = 0;
    mid(); chk("ld_done_cyc", 32'(wb_cyc_o), 32'h0);
    chk("ld_done_stb", 32'(wb_stb_o), 32'h0);
    chk("ld_done_data", cpu_data_o, 32'h0);
    chk("ld_done_stallreq", 32'(stallreq_o), 32'h0);

    // Store
    next_cycle(); req(1'b1, 32'h0000_0100, 4'b0011, 32'h0000_ABCD);
    next_cycle(); cpu_ce_i = 0; cpu_data_i = 32'hFFFF_FFFF; cpu_addr_i = 32'h0;
    mid(); chk("st_we", 32'(wb_we_o), 32'h1);
    chk("st_sel", 32'(wb_sel_o), 32'h3);
    chk("st_adr", wb_adr_o, 32'h0000_0100);
    chk("st_dat", wb_dat_o, 32'h0000_ABCD);
    next_cycle(); wb_ack_i = 1; wb_dat_i = 32'h5555_AAAA;
    mid(); chk("st_ack_adr", wb_adr_o, 32'h0000_0100);
    chk("st_ack_data", cpu_data_o, 32'h0);
    chk("st_ack_stallreq", 32'(stallreq_o), 32'h0);
    next_cycle(); wb_ack_i = 0;

    // Load acked while MEM is held
    next_cycle(); req(1'b0, 32'h0000_0200, 4'hF, 32'h0);
    next_cycle(); cpu_ce_i = 0; wb_ack_i = 1; wb_dat_i = 32'h1234_5678; stall_i = 6'b01_0000;
    mid(); chk("hold_ack_data", cpu_data_o, 32'h1234_5678);
    next_cycle(); wb_ack_i = 0; wb_dat_i = 32'hBAD0_BAD0; cpu_ce_i = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("hold_data", cpu_data_o, 32'h1234_5678);
      chk("hold_stallreq", 32'(stallreq_o), 32'h0);
      chk("hold_cyc", 32'(wb_cyc_o), 32'h0);
      next_cycle();
      if (i == 1) begin stall_i = 6'b0; cpu_ce_i = 0; end
    end
    mid(); chk("hold_exit_data", cpu_data_o, 32'h0);
    chk("hold_exit_cyc", 32'(wb_cyc_o), 32'h0);

    // Flush on 2nd BUSY cycle, late ack ignored
    next_cycle(); req(1'b0, 32'h0000_0300, 4'hF, 32'h0);
    next_cycle(); cpu_ce_i = 0;
    next_cycle(); flush_i = 1;
    mid(); chk("fl_stallreq", 32'(stallreq_o), 32'h0);
    chk("fl_data", cpu_data_o, 32'h0);
    next_cycle(); flush_i = 0; wb_ack_i = 1; wb_dat_i = 32'h7777_7777;
    mid(); chk("fl_cyc", 32'(wb_cyc_o), 32'h0);
    chk("fl_stb", 32'(wb_stb_o), 32'h0);
    chk("fl_late_data", cpu_data_o, 32'h0);
    chk("fl_late_stallreq", 32'(stallreq_o), 32'h0);
    next_cycle(); wb_ack_i = 0;
    mid(); chk("fl_idle_cyc", 32'(wb_cyc_o), 32'h0);

    // Timeout: 4 stalled BUSY cycles, abort on the 5th
    next_cycle(); req(1'b0, 32'h0000_0400, 4'hF, 32'h0);
    next_cycle(); cpu_ce_i = 0;
    for (int i = 0; i < 4; i++) begin
      mid(); chk("to_busy_stallreq", 32'(stallreq_o), 32'h1);
      chk("to_busy_err", 32'(bus_err_o), 32'h0);
      next_cycle();
    end
    mid(); chk("to_abort_stallreq", 32'(stallreq_o), 32'h0);
    chk("to_abort_data", cpu_data_o, 32'h0);
    chk("to_abort_err", 32'(bus_err_o), 32'h0);
    next_cycle(); req(1'b0, 32'h0000_0500, 4'hF, 32'h0);
    mid(); chk("to_err_pulse", 32'(bus_err_o), 32'h1);
    chk("to_err_cyc", 32'(wb_cyc_o), 32'h0);
    chk("to_next_stallreq", 32'(stallreq_o), 32'h1);
    next_cycle(); cpu_ce_i = 0; wb_ack_i = 1; wb_dat_i = 32'hCAFE_F00D;
    mid(); chk("to_err_clear", 32'(bus_err_o), 32'h0);
    chk("to_next_adr", wb_adr_o, 32'h0000_0500);
    chk("to_next_data", cpu_data_o, 32'hCAFE_F00D);
    next_cycle(); wb_ack_i = 0;

    // Asynchronous reset mid-BUSY
    next_cycle(); req(1'b1, 32'h0000_0600, 4'b1100, 32'h1111_2222);
    next_cycle(); cpu_ce_i = 0;
    mid(); chk("ar_pre_cyc", 32'(wb_cyc_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cyc", 32'(wb_cyc_o), 32'h0);
    chk("ar_stb", 32'(wb_stb_o), 32'h0);
    chk("ar_we", 32'(wb_we_o), 32'h0);
    chk("ar_sel", 32'(wb_sel_o), 32'h0);
    chk("ar_adr", wb_adr_o, 32'h0);
    chk("ar_dat", wb_dat_o, 32'h0);
    next_cycle();
    mid(); rst_n = 1'b1;
    next_cycle(); wb_ack_i = 1; wb_dat_i = 32'hAAAA_5555;
    mid(); chk("ar_post_data", cpu_data_o, 32'h0);
    chk("ar_post_stallreq", 32'(stallreq_o), 32'h0);
    chk("ar_post_cyc", 32'(wb_cyc_o), 32'h0);
    next_cycle(); wb_ack_i = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
